// File: rtl/transpose_writeback.sv
// Drains transposed 512-bit lines from the transpose output FIFO and issues sequential
// line-granular write requests; counts lines and pulses done after the last accepted write.
module transpose_writeback #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned LINES_PER_TILE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_tiles,
    input  logic [511:0]          fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [511:0]          wr_data,
    output logic                  busy,
    output logic                  done
);

    // Line counters are wide enough to hold num_tiles * LINES_PER_TILE without truncation.
    localparam int unsigned TotW = CNT_WIDTH + $clog2(LINES_PER_TILE);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [TotW-1:0]       total_q;
    logic [TotW-1:0]       rd_cnt_q;
    logic [TotW-1:0]       wr_cnt_q;
    logic [511:0]          line_q [2];
    logic                  head_q;
    logic [1:0]            occ_q;
    logic                  pend_q;

    logic                  run;
    logic                  pop;
    logic                  start_ok;
    logic                  tail;
    logic [2:0]            in_use;
    logic [TotW-1:0]       total_in;

    assign total_in = TotW'(num_tiles) * TotW'(LINES_PER_TILE);
    assign start_ok = (state_q == StIdle) && start;
    // A read can only be in flight when the buffer holds at most one line, so the
    // capture slot is always the one just past the head.
    assign tail     = head_q ^ occ_q[0];

    always_comb begin
        run      = (state_q == StRun);
        wr_valid = run && (occ_q != 2'd0);
        pop      = wr_valid && wr_ready;
        // Lines buffered or in flight once this cycle's pop has left.
        in_use   = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
        fifo_re  = run && !fifo_empty && (rd_cnt_q < total_q) && (in_use < 3'd2);
        wr_data  = line_q[head_q];
        wr_addr  = base_q + ADDR_WIDTH'(wr_cnt_q);
        busy     = run;
        done     = (state_q == StDone);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_tiles == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (pop && (wr_cnt_q + TotW'(1) == total_q)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            base_q    <= '0;
            total_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            line_q[0] <= '0;
            line_q[1] <= '0;
            head_q    <= 1'b0;
            occ_q     <= 2'd0;
            pend_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= fifo_re;
            if (start_ok) begin
                base_q   <= base_addr;
                total_q  <= total_in;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
                head_q   <= 1'b0;
                occ_q    <= 2'd0;
            end else begin
                if (fifo_re) begin
                    rd_cnt_q <= rd_cnt_q + TotW'(1);
                end
                if (pend_q) begin
                    line_q[tail] <= fifo_dout;
                end
                if (pop) begin
                    head_q   <= ~head_q;
                    wr_cnt_q <= wr_cnt_q + TotW'(1);
                end
                occ_q <= occ_q + {1'b0, pend_q} - {1'b0, pop};
            end
        end
    end

endmodule
